// File: rtl/alu_seq_ctrl_pkg.sv
// alu_seq_pkg: opcodes, flag register index and FSM state encoding for alu_seq_ctrl
package alu_seq_pkg;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SHL  = 4'd1;
    localparam logic [3:0] OP_SHR  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_MOV  = 4'd7;
    localparam logic [3:0] OP_BRZ  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;
    localparam int FLAG_ADDR = 12;
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_WB, S_HALTED} state_t;
endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: instruction handshake, register-file and ALU bus of the sequencer
interface alu_seq_ctrl_if #(parameter int RF_AW = 4, parameter int DW = 8);
    logic [8:0]       Instr;
    logic             InstrValid;
    logic             InstrReady;
    logic [RF_AW-1:0] RaddrA;
    logic [RF_AW-1:0] RaddrB;
    logic [DW-1:0]    RdataA;
    logic [DW-1:0]    RdataB;
    logic             FlagIn;
    logic [DW-1:0]    AluA;
    logic [DW-1:0]    AluB;
    logic [3:0]       AluOp;
    logic [DW-1:0]    AluOut;
    logic             AluZero;
    logic             RegWrEn;
    logic [RF_AW-1:0] WrAddr;
    logic [DW-1:0]    WrData;
    logic             FlagWrEn;
    logic             FlagData;
    logic             BranchTaken;
    logic [4:0]       BranchOff;
    logic             Done;
    logic             Halted;
    logic [15:0]      RetiredCnt;
    modport master (
        input  Instr, InstrValid, RdataA, RdataB, FlagIn, AluOut, AluZero,
        output InstrReady, RaddrA, RaddrB, AluA, AluB, AluOp, RegWrEn, WrAddr, WrData,
               FlagWrEn, FlagData, BranchTaken, BranchOff, Done, Halted, RetiredCnt
    );
    modport slave (
        output Instr, InstrValid, RdataA, RdataB, FlagIn, AluOut, AluZero,
        input  InstrReady, RaddrA, RaddrB, AluA, AluB, AluOp, RegWrEn, WrAddr, WrData,
               FlagWrEn, FlagData, BranchTaken, BranchOff, Done, Halted, RetiredCnt
    );
endinterface

// File: rtl/alu_seq_ctrl_decode.sv
// alu_seq_decode: opcode classification for the sequencer
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] op,
    output logic       is_alu,
    output logic       writes_reg,
    output logic       writes_flag,
    output logic       is_brz,
    output logic       is_halt
);
    always_comb begin
        is_alu      = op <= OP_MOV;
        writes_reg  = is_alu && op != OP_SLT;
        writes_flag = op == OP_ADD || op == OP_SLT;
        is_brz      = op == OP_BRZ;
        is_halt     = op == OP_HALT;
    end
endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle ALU sequencer (IDLE/DECODE/EXEC/WB/HALTED).
// RETIRE_CNT_EN adds a live 16-bit retired-instruction counter on RetiredCnt.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int RF_AW = 4
) (
    input logic Clk,
    input logic Reset,
    alu_seq_ctrl_if.master bus
);
    state_t     state;
    logic [3:0] op;
    logic [2:0] rd;
    logic [3:0] dec_op;
    logic       is_alu, writes_reg, writes_flag, is_brz, is_halt;
    assign dec_op = state == S_IDLE ? bus.Instr[8:5] : op;
    assign bus.InstrReady = state == S_IDLE;
    alu_seq_decode u_dec (
        .op(dec_op), .is_alu(is_alu), .writes_reg(writes_reg),
        .writes_flag(writes_flag), .is_brz(is_brz), .is_halt(is_halt)
    );
    // Non-ALU retire strobes are decoded from the incoming word so they land in the DECODE cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= S_IDLE;
            op              <= '0;
            rd              <= '0;
            bus.RaddrA      <= '0;
            bus.RaddrB      <= '0;
            bus.AluA        <= '0;
            bus.AluB        <= '0;
            bus.AluOp       <= '0;
            bus.RegWrEn     <= 1'b0;
            bus.WrAddr      <= '0;
            bus.WrData      <= '0;
            bus.FlagWrEn    <= 1'b0;
            bus.FlagData    <= 1'b0;
            bus.BranchTaken <= 1'b0;
            bus.BranchOff   <= '0;
            bus.Done        <= 1'b0;
            bus.Halted      <= 1'b0;
        end else begin
            bus.RegWrEn     <= 1'b0;
            bus.FlagWrEn    <= 1'b0;
            bus.BranchTaken <= 1'b0;
            bus.Done        <= 1'b0;
            bus.AluOp       <= '0;
            case (state)
                S_IDLE: if (bus.InstrValid) begin
                    op              <= bus.Instr[8:5];
                    rd              <= bus.Instr[4:2];
                    bus.RaddrA      <= {{(RF_AW-3){1'b0}}, bus.Instr[4:2]};
                    bus.RaddrB      <= {{(RF_AW-2){1'b0}}, bus.Instr[1:0]};
                    bus.Done        <= !is_alu && !is_halt;
                    bus.BranchTaken <= is_brz && bus.FlagIn;
                    if (is_brz) bus.BranchOff <= bus.Instr[4:0];
                    state           <= S_DECODE;
                end
                S_DECODE: begin
                    bus.AluA  <= bus.RdataA;
                    bus.AluB  <= bus.RdataB;
                    bus.AluOp <= is_alu ? op : 4'd0;
                    if (is_halt) bus.Halted <= 1'b1;
                    state     <= is_alu ? S_EXEC : is_halt ? S_HALTED : S_IDLE;
                end
                S_EXEC: begin
                    bus.RegWrEn  <= writes_reg;
                    bus.FlagWrEn <= writes_flag;
                    bus.WrAddr   <= {{(RF_AW-3){1'b0}}, rd};
                    bus.WrData   <= bus.AluOut;
                    bus.FlagData <= bus.AluZero;
                    bus.Done     <= 1'b1;
                    state        <= S_WB;
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_HALTED;
            endcase
        end
    end
`ifdef RETIRE_CNT_EN
    logic [15:0] cnt;
    always_ff @(posedge Clk) begin
        if (Reset) cnt <= '0;
        else if (bus.Done && state != S_HALTED) cnt <= cnt + 16'd1;
    end
    assign bus.RetiredCnt = cnt;
`else
    assign bus.RetiredCnt = '0;
`endif
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed scoreboard bench for alu_seq_ctrl
module tb_alu_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ret = 0;
    int   acc_cyc = 0;
    logic [20:0] sb[$];
    alu_seq_ctrl_if #(.RF_AW(4), .DW(8)) bus();
    alu_seq_ctrl dut (.Clk(clk), .Reset(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) ret = 0;
    end
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask
    task automatic push(input logic we, input logic [3:0] a, input logic [7:0] d,
                        input logic fwe, input logic fd, input logic br, input logic [4:0] off);
        sb.push_back({we, a, d, fwe, fd, br, off});
    endtask
    always @(negedge clk) begin
        if (bus.Done) begin
            logic [20:0] got;
            got = {bus.RegWrEn, bus.RegWrEn ? bus.WrAddr : 4'h0, bus.RegWrEn ? bus.WrData : 8'h0,
                   bus.FlagWrEn, bus.FlagWrEn ? bus.FlagData : 1'b0,
                   bus.BranchTaken, bus.BranchTaken ? bus.BranchOff : 5'h0};
            ret++;
            if (sb.size() == 0) chk("unexpected_done", {11'h0, got}, 32'hFFFFFFFF);
            else chk("retire", {11'h0, got}, {11'h0, sb.pop_front()});
        end
    end
    task automatic accept(input logic [8:0] ins);
        int n = 0;
        bus.Instr = ins;
        bus.InstrValid = 1'b1;
        while (!bus.InstrReady && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", n, 0);
        @(posedge clk);
        #1 acc_cyc = cyc;
    endtask
    task automatic settle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.InstrReady && n < 20);
        if (n >= 20) chk("settle_timeout", n, 0);
    endtask
    task automatic go(input logic [8:0] ins, input int lat, input string nm);
        int n = 0;
        accept(ins);
        bus.InstrValid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.Done && n < 10);
        chk(nm, n, lat);
        if (!bus.InstrReady) settle();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end
    initial begin
        int low, a1;
        bus.Instr = '0; bus.InstrValid = 0; bus.RdataA = '0; bus.RdataB = '0;
        bus.FlagIn = 0; bus.AluOut = '0; bus.AluZero = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("rst_ready", bus.InstrReady, 1);
        chk("rst_done", bus.Done, 0);
        chk("rst_halted", bus.Halted, 0);
        chk("rst_strobes", {bus.RegWrEn, bus.FlagWrEn, bus.BranchTaken}, 0);
        chk("rst_aluop", bus.AluOp, 0);
        chk("rst_wrdata", bus.WrData, 0);
        chk("rst_retcnt", bus.RetiredCnt, 0);
        // ADD r1,r2 : 0xF0 + 0x20 wraps to 0x10, carry routed through AluZero
        bus.RdataA = 8'hF0; bus.RdataB = 8'h20; bus.AluOut = 8'h10; bus.AluZero = 1;
        push(1, 4'd1, 8'h10, 1, 1, 0, 5'h0);
        accept(9'h006);
        bus.InstrValid = 0;
        @(negedge clk);
        chk("add_raddr", {bus.RaddrA, bus.RaddrB}, 8'h12);
        chk("add_done_early", bus.Done, 0);
        @(negedge clk);
        chk("add_alu_ab", {bus.AluA, bus.AluB}, 16'hF020);
        @(negedge clk);
        chk("add_done_n3", bus.Done, 1);
        settle();
        // SLT r3,r0 : flag only, AluOp visible in EXEC only
        bus.AluOut = 8'h55; bus.AluZero = 1;
        push(0, 4'd0, 8'h0, 1, 1, 0, 5'h0);
        accept(9'h0CC);
        bus.InstrValid = 0;
        @(negedge clk);
        chk("slt_op_decode", bus.AluOp, 0);
        @(negedge clk);
        chk("slt_op_exec", bus.AluOp, 6);
        @(negedge clk);
        chk("slt_op_wb", bus.AluOp, 0);
        chk("slt_done", bus.Done, 1);
        settle();
        // MOV r4,r3 then XOR r2,r1 with InstrValid held high
        bus.AluOut = 8'h3C; bus.AluZero = 0;
        push(1, 4'd4, 8'h3C, 0, 0, 0, 5'h0);
        push(1, 4'd2, 8'hA5, 0, 0, 0, 5'h0);
        accept(9'h0F3);
        a1 = acc_cyc;
        bus.Instr = 9'h0A9;
        low = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (!bus.InstrReady) low++;
        end
        bus.AluOut = 8'hA5;
        chk("b2b_ready_low", low, 3);
        accept(9'h0A9);
        chk("b2b_gap", acc_cyc - a1, 4);
        bus.InstrValid = 0;
        settle();
        // BRZ offset 5'b10011, taken then not taken
        bus.FlagIn = 1;
        push(0, 4'd0, 8'h0, 0, 0, 1, 5'h13);
        go(9'h113, 1, "brz_taken_lat");
        bus.FlagIn = 0;
        push(0, 4'd0, 8'h0, 0, 0, 0, 5'h0);
        go(9'h113, 1, "brz_not_lat");
        push(0, 4'd0, 8'h0, 0, 0, 0, 5'h0);
        go(9'h120, 1, "nop_lat");
        // Reset during EXEC of AND r2,r1 drops it
        accept(9'h069);
        bus.InstrValid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("and_op_exec", bus.AluOp, 3);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("and_rst_strobes", {bus.RegWrEn, bus.FlagWrEn, bus.Done}, 0);
        chk("and_rst_ready", bus.InstrReady, 1);
        chk("and_rst_aluop", bus.AluOp, 0);
        @(negedge clk);
        chk("and_rst_nodone", bus.Done, 0);
        // HALT is sticky until reset
        accept(9'h1E0);
        @(negedge clk);
        chk("halt_decode", bus.Halted, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_state", {bus.Halted, bus.InstrReady}, 2'b10);
        end
        bus.InstrValid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("halt_cleared", {bus.Halted, bus.InstrReady}, 2'b01);
        push(0, 4'd0, 8'h0, 0, 0, 0, 5'h0);
        go(9'h12F, 1, "nop2_lat");
        @(negedge clk);
`ifdef RETIRE_CNT_EN
        chk("retired_cnt", bus.RetiredCnt, ret);
`else
        chk("retired_cnt", bus.RetiredCnt, 0);
`endif
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
